pmem_responder: RTL and testbench

PMEM_RESPONDER -- requirements
Module: pmem_responder

---
 rtl/pkg_cache.sv | 14 +
 rtl/pmem_line_array.sv | 27 ++
 rtl/pmem_responder.sv | 112 +++++++++++
 tb/tb_pmem_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_cache.sv
// Shared constants and types for the physical-memory responder.
// Line geometry and the responder state encoding live here.
package pkg_cache;

    localparam int unsigned LINE_W   = 256;
    localparam int unsigned OFFSET_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } resp_state_e;

endpackage

// File: rtl/pmem_line_array.sv
// Line storage for the responder: one synchronous write port and one
// combinational read port. Contents survive reset.
module pmem_line_array
    import pkg_cache::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [LINE_W-1:0]     wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [LINE_W-1:0]     rdata_o
);

    // Zero initial value is a simulation convenience; hardware starts undefined.
    logic [LINE_W-1:0] mem_q [2**DEPTH_LOG2] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency line-memory responder with abort detection and
// completed-operation counters.
module pmem_responder
    import pkg_cache::*;
#(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pmem_address,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic              proto_err
);

    localparam logic [3:0] CNT_INIT =
        (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    resp_state_e           state_q;
    logic                  op_wr_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [LINE_W-1:0]     wdata_q;
    logic [3:0]            cnt_q;
    logic [15:0]           rd_count_q;
    logic [15:0]           wr_count_q;
    logic                  err_q;

    logic                  held;
    logic                  resp_ok;
    logic [LINE_W-1:0]     line_rd;
    logic                  unused_addr;

    // The captured op must stay requested; both-high counts as a write.
    assign held    = op_wr_q ? pmem_write : pmem_read;
    assign resp_ok = (state_q == ST_RESP) && held && !rst;

    assign pmem_resp  = resp_ok;
    assign pmem_rdata = (resp_ok && !op_wr_q) ? line_rd : '0;
    assign rd_count   = rd_count_q;
    assign wr_count   = wr_count_q;
    assign proto_err  = err_q;

    assign unused_addr = ^{pmem_address[31:DEPTH_LOG2+OFFSET_W],
                           pmem_address[OFFSET_W-1:0]};

    pmem_line_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_lines (
        .clk     (clk),
        .we_i    (resp_ok && op_wr_q),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .raddr_i (idx_q),
        .rdata_o (line_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_wr_q    <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pmem_read || pmem_write) begin
                        op_wr_q <= pmem_write;
                        idx_q   <= pmem_address[DEPTH_LOG2+OFFSET_W-1:OFFSET_W];
                        wdata_q <= pmem_wdata;
                        cnt_q   <= CNT_INIT;
                        if (pmem_read && pmem_write) begin
                            err_q <= 1'b1;
                        end
                        state_q <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!held) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    if (!held) begin
                        err_q <= 1'b1;
                    end else if (op_wr_q) begin
                        wr_count_q <= wr_count_q + 16'd1;
                    end else begin
                        rd_count_q <= rd_count_q + 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: a LATENCY=4 instance and a
// LATENCY=1 instance share clock and reset.
module tb_pmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           cyc;
        logic [255:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic         rd[2];
    logic         wr[2];
    logic [31:0]  addr[2];
    logic [255:0] wd[2];
    logic         resp[2];
    logic [255:0] rdata[2];
    logic [15:0]  rdc[2];
    logic [15:0]  wrc[2];
    logic         perr[2];

    logic [255:0] m0[256];
    logic [255:0] m1[256];
    logic [15:0]  erd[2];
    logic [15:0]  ewr[2];
    logic         eerr[2];

    pmem_responder #(.LATENCY(4), .DEPTH_LOG2(8)) dut0 (
        .clk(clk), .rst(rst),
        .pmem_address(addr[0]), .pmem_read(rd[0]),
        .pmem_write(wr[0]), .pmem_wdata(wd[0]),
        .pmem_rdata(rdata[0]), .pmem_resp(resp[0]),
        .rd_count(rdc[0]), .wr_count(wrc[0]),
        .proto_err(perr[0])
    );

    pmem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) dut1 (
        .clk(clk), .rst(rst),
        .pmem_address(addr[1]), .pmem_read(rd[1]),
        .pmem_write(wr[1]), .pmem_wdata(wd[1]),
        .pmem_rdata(rdata[1]), .pmem_resp(resp[1]),
        .rd_count(rdc[1]), .wr_count(wrc[1]),
        .proto_err(perr[1])
    );

    function automatic int lat(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic chk(string n, logic [255:0] a, logic [255:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic push(int i, int c, logic [255:0] d);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic mon(int i);
        exp_t e;
        bit   empty;
        empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp inst%0d: got resp at cycle %0d want none",
                     i, cyc);
        end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("resp_cycle inst%0d", i), 256'(cyc), 256'(e.cyc));
            chk($sformatf("rdata inst%0d", i), rdata[i], e.data);
        end
    endtask

    always @(negedge clk) begin
        if (resp[0]) mon(0);
        if (resp[1]) mon(1);
    end

    task automatic issue(int i, bit r, bit w, logic [31:0] a, logic [255:0] d);
        logic [7:0] x;
        bit         got;
        @(posedge clk); #1;
        rd[i] = r; wr[i] = w; addr[i] = a; wd[i] = d;
        x = a[12:5];
        if (w) begin
            if (i == 0) m0[x] = d;
            else m1[x] = d;
            push(i, cyc + lat(i), '0);
            ewr[i]++;
        end else begin
            push(i, cyc + lat(i), (i == 0) ? m0[x] : m1[x]);
            erd[i]++;
        end
        if (r && w) eerr[i] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = resp[i];
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout inst%0d: got no resp want resp", i);
        end
    endtask

    task automatic chk_state(int i);
        chk($sformatf("rd_count inst%0d", i), 256'(rdc[i]), 256'(erd[i]));
        chk($sformatf("wr_count inst%0d", i), 256'(wrc[i]), 256'(ewr[i]));
        chk($sformatf("proto_err inst%0d", i), 256'(perr[i]), 256'(eerr[i]));
    endtask

    task automatic settle(int i);
        @(posedge clk); #1;
        rd[i] = 1'b0; wr[i] = 1'b0;
        chk_state(i);
    endtask

    task automatic abort(int i, logic [31:0] a, logic [255:0] d, bit use_rst);
        @(posedge clk); #1;
        wr[i] = 1'b1; addr[i] = a; wd[i] = d;
        repeat (2) @(posedge clk);
        #1;
        wr[i] = 1'b0;
        if (use_rst) rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        if (use_rst) begin
            for (int k = 0; k < 2; k++) begin
                erd[k] = '0; ewr[k] = '0; eerr[k] = 1'b0;
            end
        end else begin
            eerr[i] = 1'b1;
        end
        repeat (8) @(posedge clk);
        #1;
        chk_state(i);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            m0[k] = '0;
            m1[k] = '0;
        end
        for (int k = 0; k < 2; k++) begin
            rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wd[k] = '0;
            erd[k] = '0; ewr[k] = '0; eerr[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_resp inst%0d", k), 256'(resp[k]), '0);
            chk($sformatf("reset_rdata inst%0d", k), rdata[k], '0);
            chk_state(k);
        end

        issue(0, 1, 0, 32'h0000_0040, '0);
        settle(0);

        issue(0, 0, 1, 32'h0000_0060, {32{8'hA5}});
        issue(0, 1, 0, 32'h0000_0060, '0);
        settle(0);

        abort(0, 32'h0000_0080, {32{8'hEE}}, 1'b0);
        issue(0, 1, 0, 32'h0000_0080, '0);
        settle(0);

        abort(0, 32'h0000_0080, {32{8'hDD}}, 1'b1);
        issue(0, 1, 0, 32'h0000_0080, '0);
        settle(0);

        issue(0, 1, 1, 32'h0000_0100, {32{8'h5A}});
        settle(0);
        issue(0, 1, 0, 32'h0000_0100, '0);
        settle(0);

        issue(0, 0, 1, 32'h0000_2040, {32{8'h77}});
        issue(0, 1, 0, 32'h0000_0040, '0);
        settle(0);

        issue(1, 1, 0, 32'h0000_0020, '0);
        issue(1, 0, 1, 32'h0000_0020, {32{8'h3C}});
        issue(1, 1, 0, 32'h0000_0020, '0);
        settle(1);

        @(posedge clk); #1;
        force dut1.wr_count_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut1.wr_count_q;
        ewr[1] = 16'hFFFF;
        chk("wr_count_preload inst1", 256'(wrc[1]), 256'(ewr[1]));
        issue(1, 0, 1, 32'h0000_0040, {32{8'h11}});
        settle(1);

        repeat (6) @(posedge clk);
        #1;
        chk("queue_drained inst0", 256'(q0.size()), '0);
        chk("queue_drained inst1", 256'(q1.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
